// File: rtl/dec_pkg.sv
// dec_pkg: shared constants and helpers for the RV32I/E decode stage.
// Holds the major opcode encodings, the immediate-format enum, the
// bit offsets of the packed operation word and the immediate generator.
package dec_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Packed operation word layout: {alt, funct3, opcode}
    localparam int OP_W       = 11;
    localparam int OP_OPC_LSB = 0;
    localparam int OP_F3_LSB  = 7;
    localparam int OP_ALT_BIT = 10;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT,
        IMM_NONE
    } imm_type_e;

    // Builds the 32-bit immediate; every format except SHAMT is
    // sign-extended from bit 31, SHAMT has a clear top bit so the later
    // sign extension to XLEN leaves it zero-extended.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e kind);
        logic [31:0] imm;
        imm = '0;
        case (kind)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'd0};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'd0, instr[24:20]};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/dec_pipe_if.sv
// dec_pipe_if: fetch, execute and write-back signals of the decode stage.
// The slave modport is the decode stage's view, master is the surroundings.
interface dec_pipe_if #(
    parameter int XLEN = 32
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [31:0]             instr_i;
    logic [XLEN-1:0]         pc_i;
    logic                    flush_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [dec_pkg::OP_W-1:0] op_o;
    logic [XLEN-1:0]         rs1_val_o;
    logic [XLEN-1:0]         rs2_val_o;
    logic [XLEN-1:0]         imm_o;
    logic [4:0]              rd_o;
    logic [XLEN-1:0]         pc_o;
    logic                    illegal_o;
    logic                    wb_en_i;
    logic [4:0]              wb_rd_i;
    logic [XLEN-1:0]         wb_data_i;

    modport slave (
        input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        input  wb_en_i, wb_rd_i, wb_data_i,
        output in_ready_o, out_valid_o, op_o, rs1_val_o, rs2_val_o,
        output imm_o, rd_o, pc_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        output wb_en_i, wb_rd_i, wb_data_i,
        input  in_ready_o, out_valid_o, op_o, rs1_val_o, rs2_val_o,
        input  imm_o, rd_o, pc_o, illegal_o
    );

endinterface

// File: rtl/dec_regfile.sv
// dec_regfile: NREG x XLEN register file, two read ports, one write port.
// x0 always reads zero. With DEC_WB_BYPASS_EN defined a same-cycle write
// is forwarded to the read ports.
module dec_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREG];

    // Storage: cleared on reset, writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports, optionally forwarding the write in flight this cycle.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
`ifdef DEC_WB_BYPASS_EN
        if (we && waddr == raddr1 && raddr1 != '0) begin
            rdata1 = wdata;
        end
        if (we && waddr == raddr2 && raddr2 != '0) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/dec_pipe.sv
// dec_pipe: RV32I/E decode stage with register file, busy-bit scoreboard
// and a single output pipeline register. Optional macro DEC_WB_BYPASS_EN
// lets a dependent instruction issue in the write-back cycle itself.
module dec_pipe
    import dec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic       clk,
    input logic       rst,
    dec_pipe_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;

    logic            opc_known;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_used;
    logic            alt;
    imm_type_e       imm_kind;

    logic            illegal;
    logic            rs1_use;
    logic            rs2_use;
    logic [4:0]      rd_eff;
    logic [XLEN-1:0] imm_ext;
    logic [OP_W-1:0] op_dec;

    logic            wb_we;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic            rs1_fwd;
    logic            rs2_fwd;
    logic            hazard;
    logic            in_ready;
    logic            acc;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            out_valid_q;
    logic [OP_W-1:0] op_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [XLEN-1:0] rs2_val_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic            illegal_q;

    // A register index exists when no bits above the register-count width are set.
    function automatic logic reg_ok(input logic [4:0] idx);
        return (idx >> AW) == 5'd0;
    endfunction

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // Major-opcode decode: which registers are touched and which immediate format applies.
    always_comb begin
        opc_known = 1'b1;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        rd_used   = 1'b0;
        alt       = 1'b0;
        imm_kind  = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                rd_used  = 1'b1;
                imm_kind = IMM_U;
            end
            OPC_JAL: begin
                rd_used  = 1'b1;
                imm_kind = IMM_J;
            end
            OPC_JALR, OPC_LOAD: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                imm_kind = IMM_I;
            end
            OPC_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm_kind = IMM_B;
            end
            OPC_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm_kind = IMM_S;
            end
            OPC_OP_IMM: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                imm_kind = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
                alt      = (funct3 == 3'b101) & instr[30];
            end
            OPC_OP: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                alt      = instr[30];
            end
            OPC_FENCE, OPC_SYSTEM: begin
                opc_known = 1'b1;
            end
            default: begin
                opc_known = 1'b0;
            end
        endcase
    end

    // An illegal instruction still travels downstream but neither reads,
    // writes nor waits on any register.
    assign illegal = ~opc_known | (instr[1:0] != 2'b11)
                   | (rs1_used & ~reg_ok(rs1))
                   | (rs2_used & ~reg_ok(rs2))
                   | (rd_used & ~reg_ok(rd));
    assign rs1_use = rs1_used & ~illegal;
    assign rs2_use = rs2_used & ~illegal;
    assign rd_eff  = (rd_used & ~illegal) ? rd : 5'd0;
    assign imm_ext = XLEN'($signed(imm_gen(instr, imm_kind)));

    // Packed operation word assembled from the field offsets.
    always_comb begin
        op_dec                       = '0;
        op_dec[OP_OPC_LSB +: 7]      = opcode;
        op_dec[OP_F3_LSB +: 3]       = funct3;
        op_dec[OP_ALT_BIT]           = alt;
    end

    assign wb_we = bus.wb_en_i & reg_ok(bus.wb_rd_i);

    dec_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (bus.wb_rd_i[AW-1:0]),
        .wdata  (bus.wb_data_i),
        .raddr1 (rs1[AW-1:0]),
        .rdata1 (rf_rd1),
        .raddr2 (rs2[AW-1:0]),
        .rdata2 (rf_rd2)
    );

    assign rs1_val = rs1_use ? rf_rd1 : '0;
    assign rs2_val = rs2_use ? rf_rd2 : '0;

`ifdef DEC_WB_BYPASS_EN
    assign rs1_fwd = wb_we & (bus.wb_rd_i == rs1);
    assign rs2_fwd = wb_we & (bus.wb_rd_i == rs2);
`else
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
`endif

    // RAW on either used source (unless forwarded) or WAW on the destination.
    assign hazard = (rs1_use & busy_q[rs1[AW-1:0]] & ~rs1_fwd)
                  | (rs2_use & busy_q[rs2[AW-1:0]] & ~rs2_fwd)
                  | ((rd_eff != 5'd0) & busy_q[rd_eff[AW-1:0]]);

    assign in_ready = (~out_valid_q | bus.out_ready_i) & ~hazard & ~bus.flush_i;
    assign acc      = bus.in_valid_i & in_ready;

    // Scoreboard next state: clears first, so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_we) begin
            busy_d[bus.wb_rd_i[AW-1:0]] = 1'b0;
        end
        if (bus.flush_i && out_valid_q && rd_q != 5'd0) begin
            busy_d[rd_q[AW-1:0]] = 1'b0;
        end
        if (acc && rd_eff != 5'd0) begin
            busy_d[rd_eff[AW-1:0]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Output pipeline register: load on accept, empty on flush or when drained.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i || (!acc && bus.out_ready_i)) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            illegal_q   <= 1'b0;
        end else if (acc) begin
            out_valid_q <= 1'b1;
            op_q        <= op_dec;
            rs1_val_q   <= rs1_val;
            rs2_val_q   <= rs2_val;
            imm_q       <= imm_ext;
            rd_q        <= rd_eff;
            pc_q        <= bus.pc_i;
            illegal_q   <= illegal;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.op_o        = op_q;
    assign bus.rs1_val_o   = rs1_val_q;
    assign bus.rs2_val_o   = rs2_val_q;
    assign bus.imm_o       = imm_q;
    assign bus.rd_o        = rd_q;
    assign bus.pc_o        = pc_q;
    assign bus.illegal_o   = illegal_q;

endmodule

// File: tb/tb_dec_pipe.sv
// tb_dec_pipe: directed bench for dec_pipe. One RV32I instance carries the
// main sequence, a second RV32E (NREG=16) instance covers register range.
// Expectations follow DEC_WB_BYPASS_EN when the bench is built with it.
module tb_dec_pipe;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dec_pipe_if #(.XLEN(32)) bus ();
    dec_pipe_if #(.XLEN(32)) bus_e ();

    dec_pipe #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    dec_pipe #(.XLEN(32), .NREG(16)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                  input logic ready, input logic flush, input logic wb_en,
                                  input logic [4:0] wb_rd, input logic [31:0] wb_data);
        bus.in_valid_i  = valid;
        bus.instr_i     = instr;
        bus.pc_i        = pc;
        bus.out_ready_i = ready;
        bus.flush_i     = flush;
        bus.wb_en_i     = wb_en;
        bus.wb_rd_i     = wb_rd;
        bus.wb_data_i   = wb_data;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dec(input string tag, input logic v, input logic [10:0] op, input logic [4:0] rd,
                             input logic [31:0] imm, input logic [31:0] pc, input logic ill);
        check_output({tag, ".valid"},   32'(bus.out_valid_o), 32'(v));
        check_output({tag, ".op"},      32'(bus.op_o),        32'(op));
        check_output({tag, ".rd"},      32'(bus.rd_o),        32'(rd));
        check_output({tag, ".imm"},     bus.imm_o,            imm);
        check_output({tag, ".pc"},      bus.pc_o,             pc);
        check_output({tag, ".illegal"}, 32'(bus.illegal_o),   32'(ill));
    endtask

    initial begin
        rst = 1'b1;
        bus_e.in_valid_i  = 1'b0;
        bus_e.instr_i     = 32'h0;
        bus_e.pc_i        = 32'h0;
        bus_e.out_ready_i = 1'b1;
        bus_e.flush_i     = 1'b0;
        bus_e.wb_en_i     = 1'b0;
        bus_e.wb_rd_i     = 5'd0;
        bus_e.wb_data_i   = 32'h0;
        apply_stimulus(0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        $display("[TB] reset state");
        check_dec("reset", 0, 11'h000, 5'd0, 32'h0, 32'h0, 0);
        check_output("reset.rs1", bus.rs1_val_o, 32'h0);
        check_output("reset.rs2", bus.rs2_val_o, 32'h0);
        check_output("reset.in_ready", 32'(bus.in_ready_o), 32'h1);

        $display("[TB] addi x1,x0,-5");
        apply_stimulus(1, 32'hFFB00093, 32'h100, 1, 0, 0, 5'd0, 32'h0);
        check_output("addi.in_ready", 32'(bus.in_ready_o), 32'h1);
        tick();
        check_dec("addi", 1, 11'h013, 5'd1, 32'hFFFFFFFB, 32'h100, 0);
        check_output("addi.rs1", bus.rs1_val_o, 32'h0);

        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd1, 32'hFFFFFFFB);
        tick();
        check_output("drain1.valid", 32'(bus.out_valid_o), 32'h0);

        $display("[TB] lw x2 then add x3,x2,x2");
        apply_stimulus(1, 32'h00002103, 32'h104, 1, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("lw", 1, 11'h103, 5'd2, 32'h0, 32'h104, 0);
        apply_stimulus(1, 32'h002101B3, 32'h108, 1, 0, 0, 5'd0, 32'h0);
        check_output("raw.in_ready0", 32'(bus.in_ready_o), 32'h0);
        tick();
        check_output("raw.valid0", 32'(bus.out_valid_o), 32'h0);
        check_output("raw.in_ready1", 32'(bus.in_ready_o), 32'h0);
        tick();
        apply_stimulus(1, 32'h002101B3, 32'h108, 1, 0, 1, 5'd2, 32'h7);
`ifdef DEC_WB_BYPASS_EN
        check_output("raw.in_ready_wb", 32'(bus.in_ready_o), 32'h1);
        tick();
        apply_stimulus(0, 32'h002101B3, 32'h108, 1, 0, 0, 5'd0, 32'h0);
`else
        check_output("raw.in_ready_wb", 32'(bus.in_ready_o), 32'h0);
        tick();
        apply_stimulus(1, 32'h002101B3, 32'h108, 1, 0, 0, 5'd0, 32'h0);
        check_output("raw.valid_wb", 32'(bus.out_valid_o), 32'h0);
        check_output("raw.in_ready_after", 32'(bus.in_ready_o), 32'h1);
        tick();
        apply_stimulus(0, 32'h002101B3, 32'h108, 1, 0, 0, 5'd0, 32'h0);
`endif
        check_dec("add", 1, 11'h033, 5'd3, 32'h0, 32'h108, 0);
        check_output("add.rs1", bus.rs1_val_o, 32'h7);
        check_output("add.rs2", bus.rs2_val_o, 32'h7);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd3, 32'd14);
        tick();
        check_output("drain2.valid", 32'(bus.out_valid_o), 32'h0);

        $display("[TB] store, branch, illegal, lui");
        apply_stimulus(1, 32'h00102423, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("sw", 1, 11'h123, 5'd0, 32'h8, 32'h10C, 0);
        check_output("sw.rs1", bus.rs1_val_o, 32'h0);
        check_output("sw.rs2", bus.rs2_val_o, 32'hFFFFFFFB);
        apply_stimulus(1, 32'hFE000EE3, 32'h110, 1, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("beq", 1, 11'h063, 5'd0, 32'hFFFFFFFC, 32'h110, 0);
        apply_stimulus(1, 32'h00000090, 32'h114, 1, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("badop", 1, 11'h010, 5'd0, 32'h0, 32'h114, 1);
        apply_stimulus(1, 32'h123454B7, 32'h118, 1, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("lui", 1, 11'h2B7, 5'd9, 32'h12345000, 32'h118, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd9, 32'h12345000);
        tick();
        check_output("drain3.valid", 32'(bus.out_valid_o), 32'h0);

        $display("[TB] back-pressure");
        apply_stimulus(1, 32'h00900393, 32'h200, 0, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("hold", 1, 11'h013, 5'd7, 32'h9, 32'h200, 0);
        apply_stimulus(1, 32'h00100413, 32'h204, 0, 0, 0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check_output("frz.in_ready", 32'(bus.in_ready_o), 32'h0);
            tick();
            check_dec("frz", 1, 11'h013, 5'd7, 32'h9, 32'h200, 0);
        end
        apply_stimulus(1, 32'h00100413, 32'h204, 1, 0, 0, 5'd0, 32'h0);
        check_output("release.in_ready", 32'(bus.in_ready_o), 32'h1);
        tick();
        check_dec("release", 1, 11'h013, 5'd8, 32'h1, 32'h204, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd7, 32'h9);
        tick();
        check_output("drain4.valid", 32'(bus.out_valid_o), 32'h0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd8, 32'h1);
        tick();

        $display("[TB] flush");
        apply_stimulus(1, 32'h008002EF, 32'h300, 0, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("jal", 1, 11'h06F, 5'd5, 32'h8, 32'h300, 0);
        apply_stimulus(0, 32'h008002EF, 32'h300, 0, 1, 0, 5'd0, 32'h0);
        check_output("flush.in_ready", 32'(bus.in_ready_o), 32'h0);
        tick();
        check_output("flush.valid", 32'(bus.out_valid_o), 32'h0);
        check_output("flush.rd", 32'(bus.rd_o), 32'h0);
        apply_stimulus(1, 32'h00128313, 32'h304, 1, 0, 0, 5'd0, 32'h0);
        check_output("postflush.in_ready", 32'(bus.in_ready_o), 32'h1);
        tick();
        check_dec("postflush", 1, 11'h013, 5'd6, 32'h1, 32'h304, 0);
        check_output("postflush.rs1", bus.rs1_val_o, 32'h0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 1, 5'd6, 32'h1);
        tick();

        $display("[TB] srai x4,x4,3");
        apply_stimulus(1, 32'h40325213, 32'h308, 1, 0, 0, 5'd0, 32'h0);
        tick();
        check_dec("srai", 1, 11'h693, 5'd4, 32'h3, 32'h308, 0);
        apply_stimulus(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        tick();

        $display("[TB] RV32E register range");
        bus_e.in_valid_i = 1'b1;
        bus_e.instr_i    = 32'h002088B3;
        bus_e.pc_i       = 32'h400;
        #1;
        check_output("e.add.in_ready", 32'(bus_e.in_ready_o), 32'h1);
        tick();
        check_output("e.add.valid", 32'(bus_e.out_valid_o), 32'h1);
        check_output("e.add.illegal", 32'(bus_e.illegal_o), 32'h1);
        check_output("e.add.rd", 32'(bus_e.rd_o), 32'h0);
        bus_e.instr_i = 32'h00100093;
        bus_e.pc_i    = 32'h404;
        #1;
        check_output("e.next.in_ready", 32'(bus_e.in_ready_o), 32'h1);
        tick();
        check_output("e.next.valid", 32'(bus_e.out_valid_o), 32'h1);
        check_output("e.next.illegal", 32'(bus_e.illegal_o), 32'h0);
        check_output("e.next.rd", 32'(bus_e.rd_o), 32'h1);
        check_output("e.next.imm", bus_e.imm_o, 32'h1);
        check_output("e.next.pc", bus_e.pc_o, 32'h404);
        bus_e.in_valid_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
